// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states,
// the hard-wired zero register index and the NOP loaded on a flush.
package pipe_pkg;

    typedef enum logic [1:0] {
        S_RUN = 2'd0,
        S_LU  = 2'd1,
        S_MEM = 2'd2
    } hz_state_e;

    localparam logic [4:0]  REG_ZERO  = 5'd0;

    // addi x0, x0, 0 -- the canonical RV32 NOP placed in flushed stages
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // True when an ID-stage source is actually read and names the EX destination
    function automatic logic src_match(input logic       use_src,
                                       input logic [4:0] rd,
                                       input logic [4:0] rs);
        return use_src && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter: counts up on inc and sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count events, holding at the maximum value instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Producer-side hazard controller for the 5-stage RV32 pipeline.
// Inserts load-use bubbles, freezes the pipe during cache misses,
// flushes IF/ID and ID/EX on EX redirects and keeps stall statistics.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int LU_BUBBLES    = 1,
    parameter int CNT_W         = 32,
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_RegisterRd,
    input  logic [4:0]       IF_ID_RegisterRs1,
    input  logic [4:0]       IF_ID_RegisterRs2,
    input  logic             IF_ID_use_rs1,
    input  logic             IF_ID_use_rs2,
    input  logic             EX_redirect,
    input  logic             ICACHE_stall,
    input  logic             DCACHE_stall,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             pipe_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             stall_timeout
);

    localparam int              MR_W   = $clog2(STALL_TIMEOUT) + 1;
    localparam logic [MR_W-1:0] TO_VAL = MR_W'(STALL_TIMEOUT);
    localparam logic [1:0]      LU_EXTRA = 2'(LU_BUBBLES - 1);

    // An out-of-range bubble count cannot be built into a sensible controller
    if (LU_BUBBLES < 1 || LU_BUBBLES > 3) begin : g_bad_lu_bubbles
        $fatal(1, "hazard_ctrl: LU_BUBBLES must be 1..3");
    end

    hz_state_e       r_state;
    hz_state_e       w_next_state;
    hz_state_e       w_eval_state;
    logic [1:0]      r_lu_cnt;
    logic [1:0]      w_next_lu_cnt;
    logic            r_resume_lu;
    logic            w_next_resume_lu;
    logic            w_mem_stall;
    logic            w_lu_hit;
    logic            w_flush_inc;
    logic [MR_W-1:0] r_mem_run;
    logic [MR_W-1:0] w_mem_run_next;
    logic            r_stall_timeout;

    assign w_mem_stall = ICACHE_stall | DCACHE_stall;

    assign w_lu_hit = ID_EX_MemRead && (ID_EX_RegisterRd != REG_ZERO) &&
                      (src_match(IF_ID_use_rs1, ID_EX_RegisterRd, IF_ID_RegisterRs1) ||
                       src_match(IF_ID_use_rs2, ID_EX_RegisterRd, IF_ID_RegisterRs2));

    // Leaving a memory freeze resumes whatever the pipe was doing before it
    assign w_eval_state = (r_state == S_MEM) ? (r_resume_lu ? S_LU : S_RUN) : r_state;

    // Mealy control outputs and next-state selection, memory stall first,
    // then redirect, then load-use handling
    always_comb begin
        PC_write         = 1'b1;
        IF_ID_write      = 1'b1;
        pipe_write       = 1'b1;
        IF_ID_flush      = 1'b0;
        ID_EX_flush      = 1'b0;
        w_flush_inc      = 1'b0;
        w_next_state     = r_state;
        w_next_lu_cnt    = r_lu_cnt;
        w_next_resume_lu = r_resume_lu;

        if (rst) begin
            w_next_state     = S_RUN;
            w_next_lu_cnt    = 2'd0;
            w_next_resume_lu = 1'b0;
        end else if (w_mem_stall) begin
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            pipe_write   = 1'b0;
            w_next_state = S_MEM;
            if (r_state != S_MEM) begin
                w_next_resume_lu = (r_state == S_LU);
            end
        end else if (EX_redirect) begin
            IF_ID_flush      = 1'b1;
            ID_EX_flush      = 1'b1;
            w_flush_inc      = 1'b1;
            w_next_state     = S_RUN;
            w_next_lu_cnt    = 2'd0;
            w_next_resume_lu = 1'b0;
        end else if (w_eval_state == S_LU) begin
            PC_write         = 1'b0;
            IF_ID_write      = 1'b0;
            ID_EX_flush      = 1'b1;
            w_next_lu_cnt    = r_lu_cnt - 2'd1;
            w_next_resume_lu = 1'b0;
            w_next_state     = (r_lu_cnt == 2'd1) ? S_RUN : S_LU;
        end else if (w_lu_hit) begin
            PC_write         = 1'b0;
            IF_ID_write      = 1'b0;
            ID_EX_flush      = 1'b1;
            w_next_resume_lu = 1'b0;
            if (LU_BUBBLES > 1) begin
                w_next_state  = S_LU;
                w_next_lu_cnt = LU_EXTRA;
            end else begin
                w_next_state  = S_RUN;
            end
        end else begin
            w_next_state     = S_RUN;
            w_next_resume_lu = 1'b0;
        end
    end

    // FSM state, remaining bubble count and pre-freeze context
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_RUN;
            r_lu_cnt    <= 2'd0;
            r_resume_lu <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_lu_cnt    <= w_next_lu_cnt;
            r_resume_lu <= w_next_resume_lu;
        end
    end

    // Length of the current memory stall, held once it hits the timeout
    always_comb begin
        w_mem_run_next = '0;
        if (w_mem_stall) begin
            w_mem_run_next = (r_mem_run == TO_VAL) ? r_mem_run : r_mem_run + 1'b1;
        end
    end

    // Track stall length and latch the timeout flag until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_run       <= '0;
            r_stall_timeout <= 1'b0;
        end else begin
            r_mem_run <= w_mem_run_next;
            if (w_mem_run_next == TO_VAL) begin
                r_stall_timeout <= 1'b1;
            end
        end
    end

    assign stall_timeout = r_stall_timeout;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (~PC_write),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances (1 and 3 load-use
// bubbles, 4-bit counters) driven by directed vectors with hand-computed
// expectations; a negedge monitor pops and compares them.
module tb_hazard_ctrl;

    localparam logic [4:0] CTL_RUN = 5'b11100;
    localparam logic [4:0] CTL_BUB = 5'b00101;
    localparam logic [4:0] CTL_FRZ = 5'b00000;
    localparam logic [4:0] CTL_RDR = 5'b11111;

    typedef struct {
        int         dut;
        logic [4:0] ctl;
        logic [3:0] stall;
        logic [3:0] flush;
        logic       to;
    } exp_t;

    logic       clk;
    logic [1:0] rstV;
    logic [1:0] memReadV;
    logic [4:0] rdV  [2];
    logic [4:0] rs1V [2];
    logic [4:0] rs2V [2];
    logic [1:0] useRs1V;
    logic [1:0] useRs2V;
    logic [1:0] redirectV;
    logic [1:0] icV;
    logic [1:0] dcV;

    logic [1:0] pcW;
    logic [1:0] ifidW;
    logic [1:0] pipeW;
    logic [1:0] ifFlushW;
    logic [1:0] idFlushW;
    logic [3:0] stallW [2];
    logic [3:0] flushW [2];
    logic [1:0] toW;

    exp_t  expQ[$];
    string nameQ[$];
    int    checks = 0;
    int    errors = 0;

    hazard_ctrl #(.LU_BUBBLES(1), .CNT_W(4), .STALL_TIMEOUT(1024)) dutA (
        .clk (clk), .rst (rstV[0]),
        .ID_EX_MemRead (memReadV[0]), .ID_EX_RegisterRd (rdV[0]),
        .IF_ID_RegisterRs1 (rs1V[0]), .IF_ID_RegisterRs2 (rs2V[0]),
        .IF_ID_use_rs1 (useRs1V[0]), .IF_ID_use_rs2 (useRs2V[0]),
        .EX_redirect (redirectV[0]), .ICACHE_stall (icV[0]), .DCACHE_stall (dcV[0]),
        .PC_write (pcW[0]), .IF_ID_write (ifidW[0]), .pipe_write (pipeW[0]),
        .IF_ID_flush (ifFlushW[0]), .ID_EX_flush (idFlushW[0]),
        .stall_cycles (stallW[0]), .flush_cnt (flushW[0]), .stall_timeout (toW[0])
    );

    hazard_ctrl #(.LU_BUBBLES(3), .CNT_W(4), .STALL_TIMEOUT(1024)) dutB (
        .clk (clk), .rst (rstV[1]),
        .ID_EX_MemRead (memReadV[1]), .ID_EX_RegisterRd (rdV[1]),
        .IF_ID_RegisterRs1 (rs1V[1]), .IF_ID_RegisterRs2 (rs2V[1]),
        .IF_ID_use_rs1 (useRs1V[1]), .IF_ID_use_rs2 (useRs2V[1]),
        .EX_redirect (redirectV[1]), .ICACHE_stall (icV[1]), .DCACHE_stall (dcV[1]),
        .PC_write (pcW[1]), .IF_ID_write (ifidW[1]), .pipe_write (pipeW[1]),
        .IF_ID_flush (ifFlushW[1]), .ID_EX_flush (idFlushW[1]),
        .stall_cycles (stallW[1]), .flush_cnt (flushW[1]), .stall_timeout (toW[1])
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs into the chosen instance and queue its expected response
    task automatic applyStimulus(input int d, input logic rstI, input logic mr,
                                 input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic u1, input logic u2,
                                 input logic rdr, input logic ic, input logic dc,
                                 input logic [4:0] eCtl, input logic [3:0] eStall,
                                 input logic [3:0] eFlush, input logic eTo,
                                 input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rstV[d]      = rstI;
        memReadV[d]  = mr;
        rdV[d]       = rd;
        rs1V[d]      = rs1;
        rs2V[d]      = rs2;
        useRs1V[d]   = u1;
        useRs2V[d]   = u2;
        redirectV[d] = rdr;
        icV[d]       = ic;
        dcV[d]       = dc;
        e.dut   = d;
        e.ctl   = eCtl;
        e.stall = eStall;
        e.flush = eFlush;
        e.to    = eTo;
        expQ.push_back(e);
        nameQ.push_back(nm);
    endtask

    // Compare one field and record the outcome
    task automatic checkOutput(input string nm, input logic [4:0] act, input logic [4:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", nm, act, expv);
        end
    endtask

    // Monitor: each cycle, pop the pending expectation and compare the DUT outputs
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e  = expQ.pop_front();
                nm = nameQ.pop_front();
                checkOutput({nm, ".ctl"},
                            {pcW[e.dut], ifidW[e.dut], pipeW[e.dut], ifFlushW[e.dut], idFlushW[e.dut]},
                            e.ctl);
                checkOutput({nm, ".stall_cycles"}, {1'b0, stallW[e.dut]}, {1'b0, e.stall});
                checkOutput({nm, ".flush_cnt"}, {1'b0, flushW[e.dut]}, {1'b0, e.flush});
                checkOutput({nm, ".stall_timeout"}, {4'd0, toW[e.dut]}, {4'd0, e.to});
            end
        end
    end

    // Directed scenario sequence followed by a bounded drain and the summary
    initial begin
        int s;
        int f;
        rstV = 2'b11; memReadV = '0; useRs1V = '0; useRs2V = '0;
        redirectV = '0; icV = '0; dcV = '0;
        for (int i = 0; i < 2; i++) begin
            rdV[i] = '0; rs1V[i] = '0; rs2V[i] = '0;
        end

        // Single-bubble instance
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, CTL_RUN, 0, 0, 0, "a_reset");
        applyStimulus(0, 0, 1, 5, 5, 0, 1, 0, 0, 0, 0, CTL_BUB, 0, 0, 0, "a_lu_hit");
        applyStimulus(0, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0, CTL_RUN, 1, 0, 0, "a_after_bubble");
        applyStimulus(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, CTL_RUN, 1, 0, 0, "a_rd_x0");
        applyStimulus(0, 0, 1, 7, 3, 7, 1, 0, 0, 0, 0, CTL_RUN, 1, 0, 0, "a_rs2_unused");
        applyStimulus(0, 0, 1, 5, 5, 0, 1, 0, 1, 0, 0, CTL_RDR, 1, 0, 0, "a_redirect_vs_lu");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, CTL_RUN, 1, 1, 0, "a_after_redirect");
        for (int i = 0; i < 20; i++) begin
            f = (1 + i > 15) ? 15 : 1 + i;
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, CTL_RDR, 1, 4'(f), 0, "a_redirect_burst");
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, CTL_RUN, 1, 15, 0, "a_flush_saturated");
        for (int k = 0; k < 1024; k++) begin
            s = (1 + k > 15) ? 15 : 1 + k;
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, CTL_FRZ, 4'(s), 15, 0, "a_icache_stall");
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, CTL_RUN, 15, 15, 1, "a_timeout_set");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, CTL_RUN, 15, 15, 1, "a_timeout_sticky");
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, CTL_RUN, 15, 15, 1, "a_reset_assert");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, CTL_RUN, 0, 0, 0, "a_reset_cleared");

        // Three-bubble instance
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, CTL_RUN, 0, 0, 0, "b_reset");
        applyStimulus(1, 0, 1, 5, 5, 0, 1, 0, 0, 0, 0, CTL_BUB, 0, 0, 0, "b_bubble1");
        applyStimulus(1, 0, 0, 0, 5, 0, 1, 0, 0, 0, 1, CTL_FRZ, 1, 0, 0, "b_dstall1");
        applyStimulus(1, 0, 0, 0, 5, 0, 1, 0, 0, 0, 1, CTL_FRZ, 2, 0, 0, "b_dstall2");
        applyStimulus(1, 0, 0, 0, 5, 0, 1, 0, 0, 0, 1, CTL_FRZ, 3, 0, 0, "b_dstall3");
        applyStimulus(1, 0, 0, 0, 5, 0, 1, 0, 0, 0, 1, CTL_FRZ, 4, 0, 0, "b_dstall4");
        applyStimulus(1, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0, CTL_BUB, 5, 0, 0, "b_bubble2");
        applyStimulus(1, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0, CTL_BUB, 6, 0, 0, "b_bubble3");
        applyStimulus(1, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0, CTL_RUN, 7, 0, 0, "b_resumed");
        applyStimulus(1, 0, 1, 5, 5, 0, 1, 0, 0, 0, 0, CTL_BUB, 7, 0, 0, "b_lu_again");
        applyStimulus(1, 1, 0, 0, 5, 0, 1, 0, 0, 0, 0, CTL_RUN, 8, 0, 0, "b_reset_in_lu");
        applyStimulus(1, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0, CTL_RUN, 0, 0, 0, "b_after_reset");
        applyStimulus(1, 0, 1, 5, 5, 0, 1, 0, 0, 0, 0, CTL_BUB, 0, 0, 0, "b_lu_pre_abort");
        applyStimulus(1, 0, 0, 0, 5, 0, 1, 0, 1, 0, 0, CTL_RDR, 1, 0, 0, "b_redirect_abort");
        applyStimulus(1, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0, CTL_RUN, 1, 1, 0, "b_no_more_bubbles");

        for (int i = 0; i < 20 && expQ.size() > 0; i++) begin
            @(posedge clk);
        end
        if (expQ.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: %0d expectations pending, required 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Producer-side hazard controller for the 5-stage RV32 pipeline. Where operand forwarding resolves hazards on the consuming side, this block decides when forwarding cannot help. It stalls IF/ID on load-use hazards and inserts ID/EX bubbles, freezes the whole pipeline on I/D-cache stalls, and flushes IF/ID and ID/EX on EX-stage redirects. It also keeps saturating stall/flush statistics and a sticky memory-stall timeout flag.

Parameters:
LU_BUBBLES, 1, bubbles inserted per load-use hazard (legal 1..3)
CNT_W, 32, width of performance counters
STALL_TIMEOUT, 1024, consecutive mem-stall cycles that set stall_timeout

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
ID_EX_MemRead  in  1  instruction in EX is a load
ID_EX_RegisterRd  in  5  destination of the instruction in EX
IF_ID_RegisterRs1  in  5  rs1 of the instruction in ID
IF_ID_RegisterRs2  in  5  rs2 of the instruction in ID
IF_ID_use_rs1  in  1  ID instruction reads rs1
IF_ID_use_rs2  in  1  ID instruction reads rs2
EX_redirect  in  1  branch taken or jump resolved in EX
ICACHE_stall  in  1  instruction cache miss in progress
DCACHE_stall  in  1  data cache miss in progress
PC_write  out  1  PC register enable
IF_ID_write  out  1  IF/ID register enable
pipe_write  out  1  enable for ID/EX, EX/MEM, MEM/WB
IF_ID_flush  out  1  load NOP into IF/ID at the next edge
ID_EX_flush  out  1  load NOP into ID/EX at the next edge
stall_cycles  out  CNT_W  cycles with PC_write=0
flush_cnt  out  CNT_W  redirect flushes taken
stall_timeout  out  1  sticky: mem stall lasted at least STALL_TIMEOUT cycles

Behaviour:
- Control outputs are Mealy: combinational from the current state and inputs, effective at the next edge.
- Counters and flags are registered.
- mem_stall = ICACHE_stall | DCACHE_stall.
- lu_hit = ID_EX_MemRead & Rd!=0 & ((use_rs1 & Rd==Rs1) | (use_rs2 & Rd==Rs2)).
- Rd==0 never creates a hazard.
- Priority: mem_stall > EX_redirect > lu_hit/S_LU.
- States: S_RUN, S_LU, S_MEM. Counter lu_cnt is 2 bits.
- Default outputs (nothing active): all *_write=1, flushes=0.
- mem_stall in any state:
  - PC_write=IF_ID_write=pipe_write=0; flushes=0.
  - Go to S_MEM; lu_cnt holds.
  - The pre-stall state is kept in a 1-bit resume_lu flag.
- S_MEM, mem_stall falls:
  - That same cycle is evaluated as S_RUN, or as S_LU if resume_lu=1.
  - Next state follows that evaluation.
- EX_redirect (no mem_stall):
  - IF_ID_flush=ID_EX_flush=1; all writes=1.
  - flush_cnt++; go to S_RUN; lu_cnt=0.
  - A redirect aborts any pending load-use bubbles.
- S_RUN with lu_hit:
  - PC_write=IF_ID_write=0, ID_EX_flush=1, pipe_write=1.
  - If LU_BUBBLES>1: go to S_LU with lu_cnt=LU_BUBBLES-1; otherwise stay in S_RUN.
- S_LU:
  - Same outputs as the lu_hit case; lu_cnt--.
  - When lu_cnt reaches 1, next state is S_RUN.
- stall_cycles increments every cycle PC_write=0.
- Both counters saturate at all-ones; no wrap.
- mem_run counter (internal, clog2(STALL_TIMEOUT)+1 bits):
  - Increments each mem_stall cycle; cleared when mem_stall=0.
  - When it reaches STALL_TIMEOUT, stall_timeout is set. It is cleared only by rst.
- Reset, including mid-stall or mid-S_LU:
  - State=S_RUN; lu_cnt, resume_lu, mem_run, counters, stall_timeout=0.
  - While rst=1, outputs equal the defaults.
- Illegal LU_BUBBLES (0 or >3) is a simulation-time fatal error.

Decomposition:
- Shared package pipe_pkg holds:
  - the state enum (S_RUN=0, S_LU=1, S_MEM=2);
  - the REG_ZERO constant (5'd0);
  - the NOP encoding used by the flush targets.
- One natural sub-module, sat_counter (parameter W; inputs inc, rst), instantiated twice for stall_cycles and flush_cnt.

Test Plan:
- Load-use: MemRead=1, Rd=5, Rs1=5, use_rs1=1, LU_BUBBLES=1 -> one cycle of PC_write=0, IF_ID_write=0, ID_EX_flush=1; stall_cycles=1.
- x0 and unused source: Rd=0=Rs1 with MemRead=1, then Rd=7=Rs2 with use_rs2=0 -> no stall, all writes=1.
- LU_BUBBLES=3 with DCACHE_stall asserted on bubble 2 for 4 cycles:
  - the 4 stall cycles are frozen (writes=0, flushes=0);
  - exactly 3 bubbles are inserted in total;
  - stall_cycles=7.
- Redirect colliding with load-use: EX_redirect=1 and lu_hit=1 in the same cycle -> both flushes=1, PC_write=1, flush_cnt=1, no bubble.
- ICACHE_stall for 1024 cycles with STALL_TIMEOUT=1024 -> stall_timeout=1 after cycle 1024 and stays 1 after the stall ends; rst clears it.
- Saturation with CNT_W=4: 20 redirects -> flush_cnt=15. rst asserted in S_LU -> next cycle state S_RUN, all writes=1.
